cbfp_blk_sched: RTL

- Scheduler in front of the stage-0 CBFP normaliser (64-point block, 16-wide batch).
- Admits 16-sample batches from the upstream butterfly with a valid/ready handshake, four batches per block.
- Holds upstream off while the normaliser processes and drains the block.
- Records each block's shift index into a per-frame table that the downstream denormalisation stage reads.
- Raises a sticky error if the normaliser stalls.

---
 rtl/cbfp_pkg.sv | 26 ++
 rtl/cbfp_idx_tbl.sv | 42 ++++
 rtl/cbfp_blk_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cbfp_pkg.sv
// cbfp_pkg: shared constants and types for the stage-0 CBFP block scheduler.
package cbfp_pkg;

   localparam int BATCH_SIZE = 16;
   localparam int BLOCK_SIZE = 64;
   localparam int FRAME_SIZE = 512;
   localparam int BPB        = BLOCK_SIZE / BATCH_SIZE;   // beats per block
   localparam int NBLK       = FRAME_SIZE / BLOCK_SIZE;   // blocks per frame
   localparam int IDX_W      = 5;
   localparam int GAP_CYC    = 2;
   localparam int TIMEOUT    = 16;

   localparam int BEAT_W = $clog2(BPB);
   localparam int BLK_W  = $clog2(NBLK);
   localparam int GAP_W  = $clog2(GAP_CYC + 1);
   localparam int TMO_W  = $clog2(TIMEOUT);

   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      GAP  = 2'd0,
      FEED = 2'd1,
      WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/cbfp_idx_tbl.sv
// cbfp_idx_tbl: NBLK x IDX_W shift-index table. One write port, one
// registered read port (1-cycle latency). Reads see the pre-write contents
// when both hit the same entry in the same cycle. All entries clear on reset.
module cbfp_idx_tbl
   import cbfp_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr_en,
   input  logic [BLK_W-1:0] wr_addr,
   input  idx_t             wr_data,
   input  logic             rd_en,
   input  logic [BLK_W-1:0] rd_addr,
   output idx_t             rd_data
);

   idx_t mem_reg [NBLK];
   idx_t rd_data_reg;

   // Table storage; cleared on reset so a fresh frame never reads stale indices
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NBLK; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (wr_en) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

   // Registered read; samples the array before this cycle's write lands
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_data_reg <= '0;
      end else if (rd_en) begin
         rd_data_reg <= mem_reg[rd_addr];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/cbfp_blk_sched.sv
// cbfp_blk_sched: admits four 16-sample beats per CBFP block, holds upstream
// off while the normaliser drains the block, records each block's shift
// index, and flags a stalled normaliser with a sticky error.
// Optional statistics outputs are built when CBFP_BLK_SCHED_STATS_EN is defined.
module cbfp_blk_sched
   import cbfp_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             up_valid,
   output logic             up_ready,
   output logic             cbfp_in_valid,
   input  logic             cbfp_valid_out,
   input  idx_t             cbfp_index,
   output logic             blk_first,
   output logic             frame_done,
   input  logic             idx_rd_en,
   input  logic [BLK_W-1:0] idx_rd_addr,
   output idx_t             idx_rd_data,
   output logic             idx_tbl_full,
   output logic             err_timeout,
   input  logic             err_clr
`ifdef CBFP_BLK_SCHED_STATS_EN
   ,
   output logic [15:0]      stat_blk_cnt,
   output idx_t             stat_idx_max,
   output idx_t             stat_idx_min
`endif
);

   state_t              state_reg,      state_next;
   logic [GAP_W-1:0]    gap_cnt_reg,    gap_cnt_next;
   logic [BEAT_W-1:0]   beat_cnt_reg,   beat_cnt_next;
   logic [BEAT_W-1:0]   out_cnt_reg,    out_cnt_next;
   logic [BLK_W-1:0]    blk_cnt_reg,    blk_cnt_next;
   logic [TMO_W-1:0]    tmo_cnt_reg,    tmo_cnt_next;
   logic                frame_done_reg, frame_done_next;
   logic                tbl_full_reg,   tbl_full_next;
   logic                err_reg,        err_next;
   logic                tbl_wr_en;
   logic                accept;

   // State and counter registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg      <= GAP;
         gap_cnt_reg    <= '0;
         beat_cnt_reg   <= '0;
         out_cnt_reg    <= '0;
         blk_cnt_reg    <= '0;
         tmo_cnt_reg    <= '0;
         frame_done_reg <= 1'b0;
         tbl_full_reg   <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         gap_cnt_reg    <= gap_cnt_next;
         beat_cnt_reg   <= beat_cnt_next;
         out_cnt_reg    <= out_cnt_next;
         blk_cnt_reg    <= blk_cnt_next;
         tmo_cnt_reg    <= tmo_cnt_next;
         frame_done_reg <= frame_done_next;
         tbl_full_reg   <= tbl_full_next;
         err_reg        <= err_next;
      end
   end

   // Next-state, counter updates and handshake outputs
   always_comb begin
      state_next      = state_reg;
      gap_cnt_next    = gap_cnt_reg;
      beat_cnt_next   = beat_cnt_reg;
      out_cnt_next    = out_cnt_reg;
      blk_cnt_next    = blk_cnt_reg;
      tmo_cnt_next    = tmo_cnt_reg;
      frame_done_next = 1'b0;
      tbl_full_next   = tbl_full_reg;
      err_next        = err_reg & ~err_clr;   // a timeout below overrides the clear
      tbl_wr_en       = 1'b0;
      up_ready        = 1'b0;

      case (state_reg)
         GAP: begin
            // Gives the normaliser its IDLE->COLLECT turnaround
            if (gap_cnt_reg == GAP_W'(GAP_CYC - 1)) begin
               gap_cnt_next = '0;
               state_next   = FEED;
            end else begin
               gap_cnt_next = gap_cnt_reg + GAP_W'(1);
            end
         end

         FEED: begin
            up_ready = 1'b1;
            if (up_valid) begin
               beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
               if (beat_cnt_reg == BEAT_W'(BPB - 1)) begin
                  state_next   = WAIT;
                  tmo_cnt_next = '0;
               end
            end
         end

         WAIT: begin
            if (cbfp_valid_out) begin
               tmo_cnt_next = '0;
               out_cnt_next = out_cnt_reg + BEAT_W'(1);
               // The block's index is valid on its first output beat
               if (out_cnt_reg == '0) begin
                  tbl_wr_en = 1'b1;
                  if (blk_cnt_reg == '0) begin
                     tbl_full_next = 1'b0;
                  end
               end
               if (out_cnt_reg == BEAT_W'(BPB - 1)) begin
                  blk_cnt_next = blk_cnt_reg + BLK_W'(1);
                  state_next   = GAP;
                  if (blk_cnt_reg == BLK_W'(NBLK - 1)) begin
                     frame_done_next = 1'b1;
                     tbl_full_next   = 1'b1;
                  end
               end
            end else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
               // Normaliser stalled: abort the frame and restart at block 0
               err_next      = 1'b1;
               beat_cnt_next = '0;
               out_cnt_next  = '0;
               blk_cnt_next  = '0;
               tmo_cnt_next  = '0;
               tbl_full_next = 1'b0;
               state_next    = GAP;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            end
         end

         default: begin
            state_next = GAP;
         end
      endcase
   end

   assign accept        = up_valid & up_ready;
   assign cbfp_in_valid = accept;
   assign blk_first     = accept && (beat_cnt_reg == '0) && (blk_cnt_reg == '0);
   assign frame_done    = frame_done_reg;
   assign idx_tbl_full  = tbl_full_reg;
   assign err_timeout   = err_reg;

   cbfp_idx_tbl u_idx_tbl (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (tbl_wr_en),
      .wr_addr (blk_cnt_reg),
      .wr_data (cbfp_index),
      .rd_en   (idx_rd_en),
      .rd_addr (idx_rd_addr),
      .rd_data (idx_rd_data)
   );

`ifdef CBFP_BLK_SCHED_STATS_EN
   logic [15:0] stat_blk_cnt_reg;
   idx_t        stat_idx_max_reg;
   idx_t        stat_idx_min_reg;

   // Running statistics, updated whenever a block index is recorded
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_blk_cnt_reg <= '0;
         stat_idx_max_reg <= '0;
         stat_idx_min_reg <= '1;
      end else if (tbl_wr_en) begin
         if (stat_blk_cnt_reg != 16'hFFFF) begin
            stat_blk_cnt_reg <= stat_blk_cnt_reg + 16'd1;
         end
         if (cbfp_index > stat_idx_max_reg) begin
            stat_idx_max_reg <= cbfp_index;
         end
         if (cbfp_index < stat_idx_min_reg) begin
            stat_idx_min_reg <= cbfp_index;
         end
      end
   end

   assign stat_blk_cnt = stat_blk_cnt_reg;
   assign stat_idx_max = stat_idx_max_reg;
   assign stat_idx_min = stat_idx_min_reg;
`endif

endmodule
